// File: rtl/tim_pkg.sv
// Shared types and constants for the general-purpose timer counter.
// Flag bit positions match the flag_clr / status bit ordering.
package tim_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } tim_state_e;

    localparam int FLAG_UPD = 0;
    localparam int FLAG_CC  = 1;

endpackage

// File: rtl/tim_tick_edge.sv
// Rising-edge detector: turns a level sampled in the clk domain into a one-cycle pulse.
// A source held high yields exactly one pulse.
module tim_tick_edge (
    input  logic clk,
    input  logic rst,
    input  logic tick_src,
    output logic tick
);

    logic tick_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tick_q <= 1'b0;
        end else begin
            tick_q <= tick_src;
        end
    end

    assign tick = tick_src & ~tick_q;

endmodule

// File: rtl/tim_counter.sv
// Auto-reload up-counter with a compare channel, PWM output and sticky flags,
// advanced by rising edges of the prescaler output sampled as data.
//
// state | meaning
// IDLE  | stopped, cnt held at 0, active regs follow shadow writes
// RUN   | counting on each tick, wrap at arr_active
// DONE  | one-shot finished, cnt held at 0, waits for start or stop
module tim_counter
    import tim_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             tick_src,
    input  logic             start,
    input  logic             stop,
    input  logic             one_shot,
    input  logic             arr_we,
    input  logic [WIDTH-1:0] arr_wdata,
    input  logic             ccr_we,
    input  logic [WIDTH-1:0] ccr_wdata,
    input  logic [1:0]       flag_clr,
    output logic [WIDTH-1:0] cnt,
    output logic             running,
    output logic             upd_flag,
    output logic             cc_flag,
    output logic             pwm_out
);

    localparam logic [WIDTH-1:0] ONE = {{(WIDTH-1){1'b0}}, 1'b1};

    tim_state_e       state, state_nxt;
    logic [WIDTH-1:0] cnt_q, cnt_nxt;
    logic [WIDTH-1:0] arr_shadow, arr_active;
    logic [WIDTH-1:0] ccr_shadow, ccr_active;
    logic [1:0]       flags_q;
    logic             tick;
    logic             upd_ev;
    logic             cc_ev;

    tim_tick_edge u_tick_edge (
        .clk      (clk),
        .rst      (rst),
        .tick_src (tick_src),
        .tick     (tick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt_q <= '0;
        end else begin
            state <= state_nxt;
            cnt_q <= cnt_nxt;
        end
    end

    // Compare is taken on the pre-tick count, so a match at arr_active still fires.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt_q;
        upd_ev    = 1'b0;
        cc_ev     = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (start) state_nxt = RUN;
            end
            RUN: begin
                if (tick) begin
                    cc_ev = (cnt_q == ccr_active);
                    if (cnt_q == arr_active) begin
                        upd_ev  = 1'b1;
                        cnt_nxt = '0;
                        if (one_shot) state_nxt = DONE;
                    end else begin
                        cnt_nxt = cnt_q + ONE;
                    end
                end
            end
            DONE: begin
                cnt_nxt = '0;
                if (start) state_nxt = RUN;
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = '0;
            end
        endcase
        if (stop) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            upd_ev    = 1'b0;
            cc_ev     = 1'b0;
        end
    end

    // Outside RUN writes take effect at once; in RUN they wait for the next update event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            arr_shadow <= '1;
            arr_active <= '1;
            ccr_shadow <= '0;
            ccr_active <= '0;
        end else begin
            if (arr_we) arr_shadow <= arr_wdata;
            if (ccr_we) ccr_shadow <= ccr_wdata;
            if (state != RUN && arr_we) begin
                arr_active <= arr_wdata;
            end else if (upd_ev) begin
                arr_active <= arr_shadow;
            end
            if (state != RUN && ccr_we) begin
                ccr_active <= ccr_wdata;
            end else if (upd_ev) begin
                ccr_active <= ccr_shadow;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            flags_q <= 2'b00;
        end else begin
            flags_q[FLAG_UPD] <= (flags_q[FLAG_UPD] & ~flag_clr[FLAG_UPD]) | upd_ev;
            flags_q[FLAG_CC]  <= (flags_q[FLAG_CC]  & ~flag_clr[FLAG_CC])  | cc_ev;
        end
    end

    assign cnt      = cnt_q;
    assign running  = (state == RUN);
    assign upd_flag = flags_q[FLAG_UPD];
    assign cc_flag  = flags_q[FLAG_CC];
    assign pwm_out  = running && (cnt_q < ccr_active);

endmodule

// File: tb/tb_tim_counter.sv
// Bench for tim_counter: directed scenarios plus random traffic, each cycle compared
// against a behavioural model of the timer kept in plain integers.
module tb_tim_counter;

    localparam int W = 8;
    localparam int M_IDLE = 0;
    localparam int M_RUN  = 1;
    localparam int M_DONE = 2;

    logic         clk = 1'b0;
    logic         rst;
    logic         tick_src;
    logic         start;
    logic         stop;
    logic         one_shot;
    logic         arr_we;
    logic [W-1:0] arr_wdata;
    logic         ccr_we;
    logic [W-1:0] ccr_wdata;
    logic [1:0]   flag_clr;
    logic [W-1:0] cnt;
    logic         running;
    logic         upd_flag;
    logic         cc_flag;
    logic         pwm_out;

    int total = 0;
    int bad   = 0;

    int m_mode, m_cnt, m_arr, m_ccr, m_arr_sh, m_ccr_sh;
    bit m_upd, m_cc, m_tq;

    bit div_en  = 0;
    int div_cnt = 0;

    int nchg, t;
    int vals[4];
    int times[4];
    bit upds[4];
    logic [W-1:0] prev;

    tim_counter #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .tick_src  (tick_src),
        .start     (start),
        .stop      (stop),
        .one_shot  (one_shot),
        .arr_we    (arr_we),
        .arr_wdata (arr_wdata),
        .ccr_we    (ccr_we),
        .ccr_wdata (ccr_wdata),
        .flag_clr  (flag_clr),
        .cnt       (cnt),
        .running   (running),
        .upd_flag  (upd_flag),
        .cc_flag   (cc_flag),
        .pwm_out   (pwm_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_cnt = 0;
        m_arr = (1 << W) - 1; m_arr_sh = (1 << W) - 1;
        m_ccr = 0; m_ccr_sh = 0;
        m_upd = 0; m_cc = 0; m_tq = 0;
    endtask

    // Applies the timer rules to the inputs present at this clock edge.
    task automatic model_update();
        bit tk, upd, cce;
        int old_mode;
        tk = tick_src && !m_tq;
        m_tq = tick_src;
        upd = 0; cce = 0;
        old_mode = m_mode;
        if (stop) begin
            m_mode = M_IDLE; m_cnt = 0;
        end else if (m_mode != M_RUN) begin
            m_cnt = 0;
            if (start) m_mode = M_RUN;
        end else if (tk) begin
            cce = (m_cnt == m_ccr);
            if (m_cnt == m_arr) begin
                upd = 1; m_cnt = 0;
                if (one_shot) m_mode = M_DONE;
            end else begin
                m_cnt = m_cnt + 1;
            end
        end
        if (upd) begin
            m_arr = m_arr_sh; m_ccr = m_ccr_sh;
        end
        if (arr_we) begin
            m_arr_sh = int'(arr_wdata);
            if (old_mode != M_RUN) m_arr = int'(arr_wdata);
        end
        if (ccr_we) begin
            m_ccr_sh = int'(ccr_wdata);
            if (old_mode != M_RUN) m_ccr = int'(ccr_wdata);
        end
        m_upd = (m_upd && !flag_clr[0]) || upd;
        m_cc  = (m_cc  && !flag_clr[1]) || cce;
    endtask

    task automatic compare_model();
        check("cnt", 32'(cnt), 32'(m_cnt));
        check("running", 32'(running), 32'(m_mode == M_RUN));
        check("upd_flag", 32'(upd_flag), 32'(m_upd));
        check("cc_flag", 32'(cc_flag), 32'(m_cc));
        check("pwm_out", 32'(pwm_out), 32'((m_mode == M_RUN) && (m_cnt < m_ccr)));
    endtask

    task automatic step();
        if (div_en) begin
            div_cnt++;
            if (div_cnt == 2) begin
                div_cnt = 0;
                tick_src = ~tick_src;
            end
        end
        @(posedge clk);
        model_update();
        #1;
        compare_model();
        start = 0; stop = 0; arr_we = 0; ccr_we = 0; flag_clr = 2'b00;
    endtask

    task automatic tpulse();
        tick_src = 1; step();
        tick_src = 0; step();
    endtask

    task automatic write_arr(input int v);
        arr_we = 1; arr_wdata = W'(v); step();
    endtask

    task automatic write_ccr(input int v);
        ccr_we = 1; ccr_wdata = W'(v); step();
    endtask

    initial begin
        rst = 1; tick_src = 0; start = 0; stop = 0; one_shot = 0;
        arr_we = 0; arr_wdata = '0; ccr_we = 0; ccr_wdata = '0; flag_clr = 2'b00;
        model_reset();
        #3;
        check("rst_cnt", 32'(cnt), 0);
        check("rst_running", 32'(running), 0);
        check("rst_flags", 32'({upd_flag, cc_flag}), 0);
        check("rst_pwm", 32'(pwm_out), 0);
        #9 rst = 0;

        // Prescaler-driven ticks every 4 clk, ARR=3 continuous.
        write_arr(3);
        start = 1; step();
        div_en = 1; div_cnt = 0;
        nchg = 0; t = 0; prev = cnt;
        for (int i = 0; i < 40 && nchg < 4; i++) begin
            step();
            t++;
            if (cnt !== prev) begin
                vals[nchg] = int'(cnt); times[nchg] = t; upds[nchg] = upd_flag;
                nchg++; prev = cnt;
            end
        end
        check("t1_nchg", nchg, 4);
        if (nchg == 4) begin
            check("t1_v0", vals[0], 1);
            check("t1_v1", vals[1], 2);
            check("t1_v2", vals[2], 3);
            check("t1_v3", vals[3], 0);
            check("t1_gap1", times[1] - times[0], 4);
            check("t1_gap2", times[2] - times[1], 4);
            check("t1_gap3", times[3] - times[2], 4);
            check("t1_upd_pre", 32'(upds[2]), 0);
            check("t1_upd_wrap", 32'(upds[3]), 1);
        end
        div_en = 0; tick_src = 0;
        stop = 1; step();

        // One-shot, ARR=2.
        flag_clr = 2'b11; write_arr(2);
        one_shot = 1; start = 1; step();
        repeat (3) tpulse();
        check("os_cnt", 32'(cnt), 0);
        check("os_running", 32'(running), 0);
        check("os_upd", 32'(upd_flag), 1);
        repeat (2) tpulse();
        check("os_hold", 32'(cnt), 0);
        start = 1; step();
        check("os_restart", 32'(running), 1);
        tpulse();
        check("os_count", 32'(cnt), 1);

        // Compare channel, ARR=9 CCR=4.
        stop = 1; step();
        one_shot = 0;
        write_arr(9); write_ccr(4);
        flag_clr = 2'b11; step();
        start = 1; step();
        for (int i = 0; i < 20 && m_cnt != 4; i++) tpulse();
        check("cc_at4", 32'(cnt), 4);
        check("cc_pwm4", 32'(pwm_out), 0);
        check("cc_pre", 32'(cc_flag), 0);
        tpulse();
        check("cc_set", 32'(cc_flag), 1);
        flag_clr = 2'b10; step();
        check("cc_clr", 32'(cc_flag), 0);
        for (int i = 0; i < 20 && m_cnt != 4; i++) tpulse();
        tick_src = 1; flag_clr = 2'b10; step();
        check("cc_setwins", 32'(cc_flag), 1);
        tick_src = 0; step();

        // ARR preload while running.
        stop = 1; step();
        write_arr(5);
        start = 1; step();
        tpulse();
        write_arr(2);
        repeat (4) tpulse();
        check("pl_reach5", 32'(cnt), 5);
        tpulse();
        check("pl_wrap5", 32'(cnt), 0);
        repeat (2) tpulse();
        check("pl_reach2", 32'(cnt), 2);
        tpulse();
        check("pl_wrap2", 32'(cnt), 0);
        stop = 1; step();
        write_arr(7);
        start = 1; step();
        repeat (7) tpulse();
        check("idle_arr7", 32'(cnt), 7);
        tpulse();
        check("idle_wrap7", 32'(cnt), 0);

        // start and stop together.
        stop = 1; step();
        start = 1; stop = 1; step();
        check("ss_running", 32'(running), 0);

        // Asynchronous reset mid-count.
        start = 1; step();
        repeat (3) tpulse();
        check("rm_cnt3", 32'(cnt), 3);
        #2 rst = 1;
        #1;
        check("rm_cnt", 32'(cnt), 0);
        check("rm_running", 32'(running), 0);
        check("rm_flags", 32'({upd_flag, cc_flag}), 0);
        check("rm_pwm", 32'(pwm_out), 0);
        model_reset();
        #2 rst = 0;

        // ARR=0: every tick is an update.
        write_arr(0);
        start = 1; step();
        tpulse();
        check("a0_cnt", 32'(cnt), 0);
        check("a0_upd", 32'(upd_flag), 1);
        repeat (4) begin
            tpulse();
            check("a0_hold", 32'(cnt), 0);
        end

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            tick_src = 1'($urandom_range(0, 1));
            start    = ($urandom_range(0, 15) == 0);
            stop     = ($urandom_range(0, 39) == 0);
            if ($urandom_range(0, 99) == 0) one_shot = ~one_shot;
            if ($urandom_range(0, 9) == 0) begin
                arr_we = 1; arr_wdata = W'($urandom_range(0, 12));
            end
            if ($urandom_range(0, 9) == 0) begin
                ccr_we = 1; ccr_wdata = W'($urandom_range(0, 14));
            end
            if ($urandom_range(0, 7) == 0) flag_clr = 2'($urandom_range(1, 3));
            step();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
